adder_reg: RTL and testbench
============================

Name: adder_reg

Overview:
- Registered adder. Sums two unsigned BITWIDTH-bit operands and presents the full-precision result, including the carry-out, from an output register.
- One-cycle pipeline stage for datapaths that need a clean registered sum.
- Supports clock enable (hold) and synchronous clear.

Parameters:
- BITWIDTH, 32, width of each input operand. Output is BITWIDTH+1 bits.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRstN  input  1  reset, asynchronous, active-low.
- iEn  input  1  enable; 1 = load new sum, 0 = hold.
- iClr  input  1  synchronous clear of the output register.
- iData0  input  BITWIDTH  operand A, unsigned.
- iData1  input  BITWIDTH  operand B, unsigned.
- oData  output  BITWIDTH+1  registered sum A+B; MSB is the carry-out.

Behaviour:
- Reset:
  - iRstN low forces oData to 0 immediately, without waiting for a clock edge.
  - oData holds 0 while reset is asserted.
  - The first rising edge after deassertion is a normal update.
- Arithmetic:
  - Unsigned addition, zero-extended to BITWIDTH+1 bits. No overflow or truncation is possible.
  - Maximum result is 2^(BITWIDTH+1)-2.
  - Purely combinational adder, no internal pipelining.
- Latency:
  - Exactly 1 cycle.
  - Operands sampled at rising edge N appear on oData right after edge N and stay stable until the next qualifying edge.
  - With iEn=1 held, oData at cycle N+1 equals iData0+iData1 sampled at edge N.
- Priority at each rising edge, highest first:
  - iRstN low (asynchronous)
  - iClr=1 → oData <= 0, regardless of iEn
  - iEn=1 → oData <= iData0+iData1
  - otherwise oData holds its value.
- iClr held high keeps oData at 0 for as long as it is asserted.
- Deasserting iClr with iEn=1 loads the current sum on the next edge.
- iEn=0 freezes oData indefinitely; operand changes have no effect.
- Reset mid-operation: oData drops to 0 asynchronously. No other state exists.
- No combinational path from inputs to oData. oData is driven only by flops.
- The design must work for any BITWIDTH >= 1.

Test Plan:
- Reset: iRstN=0 for 20 cycles with iData0=5, iData1=7, iEn=1 → oData=0 throughout. After release, the first edge gives oData=12.
- Random stream: iEn=1, iClr=0, 100 cycles of random 32-bit operands → each cycle oData equals the previous cycle's iData0+iData1, 33-bit.
- Carry/boundary:
  - iData0=iData1=32'hFFFFFFFF → oData=33'h1FFFFFFFE one cycle later.
  - 32'hFFFFFFFF+1 → 33'h100000000.
  - 0+0 → 0.
- Enable hold: load 10+20 (oData=30), drop iEn, change operands to 1+1 for 5 cycles → oData stays 30. Raise iEn → oData=2 next cycle.
- Clear: iClr=1 with iEn=1 and operands 100+200 → oData=0 next cycle and stays 0 while iClr=1. Drop iClr → oData=300 one cycle later.
- Async reset mid-stream: pull iRstN low between clock edges while oData is nonzero → oData=0 before the next edge.

Source files
------------

// File: rtl/adder_reg.sv
// Registered full-precision adder: oData = iData0 + iData1 one cycle later,
// with the carry-out kept as the MSB. The register supports a hold and a synchronous clear.
module adder_reg #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData0,
  input  logic [BITWIDTH-1:0] iData1,
  output logic [BITWIDTH:0]   oData
);

  // Zero-extend both operands before adding, so the carry lands in the MSB.
  function automatic logic [BITWIDTH:0] add_full(
    input logic [BITWIDTH-1:0] a,
    input logic [BITWIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [BITWIDTH:0] sum_p0;
  logic [BITWIDTH:0] sum_p1;

  assign sum_p0 = add_full(iData0, iData1);

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sum_p1 <= '0;
    end else if (iClr) begin
      sum_p1 <= '0;
    end else if (iEn) begin
      sum_p1 <= sum_p0;
    end
  end

  assign oData = sum_p1;

endmodule

// File: tb/tb_adder_reg.sv
// Directed bench for adder_reg: a reset sequence, a vector table for the carry, hold and clear cases,
// a random stream against a reference sum, and an asynchronous reset applied mid-cycle.
module tb_adder_reg;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   q;

  int vectors;
  int miscompares;

  typedef struct {
    logic         en;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  adder_reg #(.BITWIDTH(W)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .iEn   (en),
    .iClr  (clr),
    .iData0(a),
    .iData1(b),
    .oData (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 ns later.
  task automatic step(input logic e, input logic c, input logic [W-1:0] x, input logic [W-1:0] y);
    en = e; clr = c; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic c, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W:0] exp, input string n);
    vec_t v;
    v.en = e; v.clr = c; v.a = x; v.b = y; v.exp = exp; v.name = n;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rexp;

    vectors = 0;
    miscompares = 0;

    // Each entry's expectation is oData after the edge on which that entry is applied.
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, "max_plus_max"));
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, "carry_out"));
    tbl.push_back(mk(1, 0, 32'd0,         32'd0,         33'd0,          "zero_plus_zero"));
    tbl.push_back(mk(1, 0, 32'd10,        32'd20,        33'd30,         "load_30"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 32'd1, 32'd1, 33'd30, "hold_30"));
    tbl.push_back(mk(1, 0, 32'd1,         32'd1,         33'd2,          "reenable_2"));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 32'd100, 32'd200, 33'd0, "clear_held"));
    tbl.push_back(mk(1, 0, 32'd100,       32'd200,       33'd300,        "clear_release_300"));
    tbl.push_back(mk(0, 1, 32'd5,         32'd6,         33'd0,          "clear_without_en"));
    tbl.push_back(mk(0, 0, 32'd7,         32'd8,         33'd0,          "hold_after_clear"));
    tbl.push_back(mk(1, 0, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, "msb_carry"));
    tbl.push_back(mk(1, 0, 32'h1234_5678, 32'h0FED_CBA9, 33'h0_2222_2221, "mixed_sum"));

    // Reset held for 20 cycles with a live sum on the inputs.
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; a = 32'd5; b = 32'd7;
    #1;
    check("reset_immediate", q, '0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", q, '0);
    end
    rst_n = 1'b1;
    step(1, 0, 32'd5, 32'd7);
    check("first_edge_after_reset", q, 33'd12);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].a, tbl[i].b);
      check(tbl[i].name, q, tbl[i].exp);
    end

    // Random stream: each sample reflects the operands driven one edge earlier.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      rexp = {1'b0, ra} + {1'b0, rb};
      step(1, 0, ra, rb);
      check("random_stream", q, rexp);
    end

    // Async reset pulled low between edges while oData is nonzero.
    step(1, 0, 32'd3, 32'd4);
    check("pre_async_reset", q, 33'd7);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", q, '0);
    @(posedge clk);
    #1;
    check("async_reset_holds", q, '0);
    rst_n = 1'b1;
    step(1, 0, 32'd2, 32'd2);
    check("after_async_release", q, 33'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1, "timeout");
  end

endmodule
